// File: rtl/seq_mul_r32m.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_mul_r32m : iterative RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU)
// Revision     : 1.0
// ---------------------------------------------------------------------------
module seq_mul_r32m #(
  parameter int dataW = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [dataW-1:0] M,
  input  logic [dataW-1:0] Q,
  input  logic [1:0]       mulCode,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [dataW-1:0] out,
  output logic             busy
);

  localparam int ITER = dataW / STEP;
  localparam int CW   = $clog2(ITER + 1);

  // Encoding chosen so the handshake outputs are direct state-flop bits.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b11
  } state_t;

  state_t               state;
  logic [1:0]           mode;
  logic                 neg;
  logic [dataW:0]       mcand;
  logic [dataW:0]       mplier;
  logic [2*dataW-1:0]   acc;
  logic [CW-1:0]        cnt;

  logic                 sign_m, sign_q;
  logic [dataW:0]       ext_m, ext_q, mag_m, mag_q;
  logic [dataW+STEP:0]  pp, sum;
  logic [2*dataW+STEP:0] wide;
  logic [2*dataW-1:0]   acc_next, prod;
  logic                 unused_bits;

  always_comb begin
    sign_m = (mulCode != 2'b11) && M[dataW-1];
    sign_q = !mulCode[1] && Q[dataW-1];
    ext_m  = {sign_m, M};
    ext_q  = {sign_q, Q};
    mag_m  = sign_m ? -ext_m : ext_m;
    mag_q  = sign_q ? -ext_q : ext_q;
  end

  // Add the partial product into the upper half, then shift the whole
  // accumulator right by STEP so the next digit lands at the same weight.
  always_comb begin
    pp       = {{STEP{1'b0}}, mcand} * {{(dataW+1){1'b0}}, mplier[STEP-1:0]};
    sum      = {{(STEP+1){1'b0}}, acc[2*dataW-1:dataW]} + pp;
    wide     = {sum, acc[dataW-1:0]};
    acc_next = wide[2*dataW+STEP-1:STEP];
    prod     = neg ? -acc : acc;
  end

  assign unused_bits = ^{wide[2*dataW+STEP], wide[STEP-1:0]};

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state  <= S_IDLE;
      mode   <= '0;
      neg    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
    end else if (kill) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mode   <= mulCode;
            neg    <= sign_m ^ sign_q;
            mcand  <= mag_m;
            mplier <= mag_q;
            acc    <= '0;
            cnt    <= CW'(ITER);
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt != '0) begin
            acc    <= acc_next;
            mplier <= mplier >> STEP;
            cnt    <= cnt - CW'(1);
          end else begin
            state <= S_DONE;
            out   <= (mode == 2'b00) ? prod[dataW-1:0] : prod[2*dataW-1:dataW];
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = state[0];
  assign out_valid = state[1];
  assign in_ready  = !state[0];

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_r32m.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_mul_r32m : directed self-checking bench, STEP=1 and STEP=4 in parallel
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_seq_mul_r32m;

  logic        clk = 1'b0;
  logic        nReset;
  logic        in_valid, kill, out_ready;
  logic [31:0] M, Q;
  logic [1:0]  mulCode;
  logic        rdy1, ov1, busy1, rdy4, ov4, busy4;
  logic [31:0] out1, out4;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  seq_mul_r32m #(.dataW(32), .STEP(1)) u_s1 (
    .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_ready(rdy1),
    .M(M), .Q(Q), .mulCode(mulCode), .kill(kill), .out_valid(ov1),
    .out_ready(out_ready), .out(out1), .busy(busy1)
  );

  seq_mul_r32m #(.dataW(32), .STEP(4)) u_s4 (
    .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_ready(rdy4),
    .M(M), .Q(Q), .mulCode(mulCode), .kill(kill), .out_valid(ov4),
    .out_ready(out_ready), .out(out4), .busy(busy4)
  );

  task automatic run_op(input string name, input logic [1:0] code,
                        input logic [31:0] m, input logic [31:0] q,
                        input logic [31:0] exp);
    int lat1, lat4;
    @(negedge clk);
    checks++;
    if ({rdy1, rdy4} !== 2'b11) begin
      errors++;
      $display("FAIL %s ready: got %b%b expected 11", name, rdy1, rdy4);
    end
    M = m; Q = q; mulCode = code; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; M = 32'hA5A5_5A5A; Q = 32'h5A5A_A5A5; mulCode = 2'b10;
    checks++;
    if ({busy1, busy4, ov1, ov4} !== 4'b1100) begin
      errors++;
      $display("FAIL %s start: busy/ov got %b%b%b%b expected 1100", name, busy1, busy4, ov1, ov4);
    end
    lat1 = 0; lat4 = 0;
    for (int e = 1; e <= 60 && (lat1 == 0 || lat4 == 0); e++) begin
      @(negedge clk);
      if (ov1 && lat1 == 0) lat1 = e;
      if (ov4 && lat4 == 0) lat4 = e;
    end
    checks++;
    if (lat1 !== 33 || lat4 !== 9) begin
      errors++;
      $display("FAIL %s latency: got %0d/%0d expected 33/9", name, lat1, lat4);
    end
    checks++;
    if (out1 !== exp || out4 !== exp) begin
      errors++;
      $display("FAIL %s result: got %h/%h expected %h", name, out1, out4, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({rdy1, rdy4, ov1, ov4} !== 4'b1100) begin
      errors++;
      $display("FAIL %s handshake: rdy/ov got %b%b%b%b expected 1100", name, rdy1, rdy4, ov1, ov4);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    M = '0; Q = '0; mulCode = 2'b00;
    #3;
    checks++;
    if ({rdy1, ov1, busy1, out1, rdy4, ov4, busy4, out4} !== {3'b100, 32'h0, 3'b100, 32'h0}) begin
      errors++;
      $display("FAIL reset: got %b%b%b %h / %b%b%b %h expected 100 0", rdy1, ov1, busy1, out1,
               rdy4, ov4, busy4, out4);
    end
    repeat (2) @(negedge clk);
    nReset = 1'b1;
  endtask

  task automatic test_modes();
    run_op("mul_ffff",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("mulh_min",     2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu_ffff",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu_ffff",  2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_7xm3",    2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("mul_7xm3",     2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulhsu_7xbig", 2'b10, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006);
    run_op("mulh_minmax",  2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000);
    run_op("mul_zero",     2'b00, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000);
  endtask

  task automatic test_backpressure();
    int waited;
    @(negedge clk);
    M = 32'h0000_0007; Q = 32'hFFFF_FFFD; mulCode = 2'b00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({busy1, ov1} !== 2'b10) begin
      errors++;
      $display("FAIL bp_ignore_ready: busy/ov got %b%b expected 10", busy1, ov1);
    end
    waited = 0;
    while (!ov1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({ov1, ov4, rdy1, rdy4} !== 4'b1100 || out1 !== 32'hFFFF_FFEB || out4 !== 32'hFFFF_FFEB) begin
        errors++;
        $display("FAIL bp_hold%0d: ov/rdy got %b%b%b%b out %h/%h expected 1100 ffffffeb", c,
                 ov1, ov4, rdy1, rdy4, out1, out4);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({rdy1, rdy4, ov1, ov4} !== 4'b1100) begin
      errors++;
      $display("FAIL bp_release: rdy/ov got %b%b%b%b expected 1100", rdy1, rdy4, ov1, ov4);
    end
  endtask

  task automatic test_kill();
    logic saw_valid;
    @(negedge clk);
    M = 32'd9; Q = 32'd9; mulCode = 2'b00; in_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    checks++;
    if ({rdy1, rdy4, busy1, busy4} !== 4'b1100) begin
      errors++;
      $display("FAIL kill_vs_accept: rdy/busy got %b%b%b%b expected 1100", rdy1, rdy4, busy1, busy4);
    end
    M = 32'h1234_5678; Q = 32'h0000_0100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checks++;
    if ({rdy1, rdy4, busy1, busy4, ov1, ov4} !== 6'b110000) begin
      errors++;
      $display("FAIL kill_busy: rdy/busy/ov got %b%b%b%b%b%b expected 110000", rdy1, rdy4,
               busy1, busy4, ov1, ov4);
    end
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov1 || ov4) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_no_valid: out_valid seen %b expected 0", saw_valid);
    end
    run_op("mul_3x5", 2'b00, 32'd3, 32'd5, 32'd15);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    M = 32'h8000_0000; Q = 32'h8000_0000; mulCode = 2'b01; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 nReset = 1'b0;
    #1;
    checks++;
    if ({rdy1, ov1, busy1, out1, rdy4, ov4, busy4, out4} !== {3'b100, 32'h0, 3'b100, 32'h0}) begin
      errors++;
      $display("FAIL async_reset: got %b%b%b %h / %b%b%b %h expected 100 0", rdy1, ov1, busy1, out1,
               rdy4, ov4, busy4, out4);
    end
    @(negedge clk);
    nReset = 1'b1;
    run_op("mulhu_2p16", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_kill();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
